dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 34 +++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// request payload, widths and the address-legality check.
package dmem_responder_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_LANES = WORD_W / BYTE_W;
   localparam int unsigned CNT_W     = 4;

   localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic                 write;
      logic [WORD_W-1:0]    addr;
      logic [WORD_W-1:0]    wdata;
      logic [NUM_LANES-1:0] be;
   } dmem_req_t;

   // Misaligned, below the window, or past the last stored word.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] base,
                                     input int unsigned       depth);
      logic [WORD_W-1:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= WORD_W'(depth));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte-lane synchronous write and a registered read
// port; contents survive reset.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [AW-1:0]        addr_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [NUM_LANES-1:0] be_i,
   output logic [WORD_W-1:0]    rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (be_i[k]) mem_q[addr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
         end
      end
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request, fixed
// wait-state latency, held response with error flag for illegal addresses.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned       MEMORY_DEPTH = 128,
   parameter int unsigned       WAIT_STATES  = 2,
   parameter logic [WORD_W-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_write_i,
   input  logic [WORD_W-1:0]    addr_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [NUM_LANES-1:0] be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [WORD_W-1:0]    rdata_o,
   output logic                 rsp_error_o
);

   localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : CNT_W'(0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dmem_req_t         req_q, req_d;
   dmem_req_t         in_req_c, enter_req_c;
   logic              enter_resp_c, enter_err_c;
   logic              mem_we_c, mem_re_c;
   logic [WORD_W-1:0] word_off_c, mem_rdata;
   logic [AW-1:0]     mem_addr_c;
   logic              rsp_err_c;

   assign in_req_c = '{write: req_write_i, addr: addr_i, wdata: wdata_i, be: be_i};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   // With zero wait states the array is accessed on the acceptance edge, so
   // the live request is used instead of the not-yet-loaded capture register.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      enter_req_c  = req_q;
      enter_resp_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               req_d       = in_req_c;
               enter_req_c = in_req_c;
               if (WAIT_STATES == 0) begin
                  state_d      = ST_RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d      = ST_RESP;
               enter_resp_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_err_c = addr_err(enter_req_c.addr, BASE_ADDR, MEMORY_DEPTH);
   assign word_off_c  = enter_req_c.addr - BASE_ADDR;
   assign mem_addr_c  = AW'(word_off_c >> 2);
   assign mem_we_c    = enter_resp_c && enter_req_c.write && !enter_err_c;
   assign mem_re_c    = enter_resp_c && !enter_req_c.write && !enter_err_c;

   dmem_array #(
      .DEPTH (MEMORY_DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we_c),
      .re_i    (mem_re_c),
      .addr_i  (mem_addr_c),
      .wdata_i (enter_req_c.wdata),
      .be_i    (enter_req_c.be),
      .rdata_o (mem_rdata)
   );

   // Response fields are decoded from held registers, so they stay stable in RESP.
   assign rsp_err_c   = addr_err(req_q.addr, BASE_ADDR, MEMORY_DEPTH);
   assign req_ready_o = (state_q == ST_IDLE) && reset;
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_error_o = rsp_valid_o && rsp_err_c;
   assign rdata_o     = (rsp_valid_o && !req_q.write && !rsp_err_c) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid_i, req_ready_o, req_write_i;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic [3:0]  be_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_error_o;

   int n_checks = 0;
   int n_errors = 0;

   dmem_responder dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .be_i        (be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rdata_o     (rdata_o),
      .rsp_error_o (rsp_error_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready_o && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!req_ready_o) check("ready_timeout", 32'(req_ready_o), 32'd1);
   endtask

   // One full transaction; inputs are scrambled after acceptance, and the
   // response is held for 'hold' cycles before the handshake.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold, input logic early_rdy,
                       output logic [31:0] rd, output logic er);
      int lat;
      wait_ready();
      req_valid_i = 1'b1; req_write_i = w; addr_i = a; wdata_i = d; be_i = be;
      @(posedge clk); #1;
      req_valid_i = 1'b0; req_write_i = ~w; addr_i = ~a; wdata_i = ~d; be_i = ~be;
      rsp_ready_i = early_rdy;
      lat = 1;
      while (!rsp_valid_o && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      rsp_ready_i = 1'b0;
      check("latency", 32'(lat), 32'd3);
      rd = rdata_o;
      er = rsp_error_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid_o), 32'd1);
         check("hold_rdata", rdata_o, rd);
         check("hold_ready", 32'(req_ready_o), 32'd0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      check("post_idle_ready", 32'(req_ready_o), 32'd1);
      check("post_idle_valid", 32'(rsp_valid_o), 32'd0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic exp_err);
      logic [31:0] rd;
      logic        er;
      xact(1'b1, a, d, be, 0, 1'b0, rd, er);
      check("store_err", 32'(er), 32'(exp_err));
      check("store_rdata", rd, 32'd0);
   endtask

   task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                       input logic exp_err);
      logic [31:0] rd;
      logic        er;
      xact(1'b0, a, 32'h0, 4'h0, 0, 1'b0, rd, er);
      check(tag, rd, exp_d);
      check({tag, "_err"}, 32'(er), 32'(exp_err));
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;

      reset = 1'b0;
      req_valid_i = 1'b0; req_write_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      rsp_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      reset = 1'b1;
      #1;
      check("idle_ready", 32'(req_ready_o), 32'd1);
      check("idle_valid", 32'(rsp_valid_o), 32'd0);
      check("idle_rdata", rdata_o, 32'd0);

      store(32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
      load("ld_full", 32'h1001_0004, 32'hDEAD_BEEF, 1'b0);
      store(32'h1001_0004, 32'h0000_00AA, 4'b0001, 1'b0);
      load("ld_lane0", 32'h1001_0004, 32'hDEAD_BEAA, 1'b0);
      store(32'h1001_0004, 32'h5500_0000, 4'b1000, 1'b0);
      load("ld_lane3", 32'h1001_0004, 32'h55AD_BEAA, 1'b0);
      store(32'h1001_0004, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      load("ld_be0", 32'h1001_0004, 32'h55AD_BEAA, 1'b0);

      store(32'h1001_0000, 32'h1111_1111, 4'hF, 1'b0);
      store(32'h1001_01FC, 32'hA5A5_5A5A, 4'hF, 1'b0);
      load("ld_last", 32'h1001_01FC, 32'hA5A5_5A5A, 1'b0);

      load("ld_misalign", 32'h1001_0002, 32'h0, 1'b1);
      load("ld_oob", 32'h1001_0200, 32'h0, 1'b1);
      load("ld_low", 32'h0000_0000, 32'h0, 1'b1);
      load("ld_below", 32'h1000_FFFC, 32'h0, 1'b1);
      store(32'h1001_0200, 32'h9999_9999, 4'hF, 1'b1);
      store(32'h1001_0001, 32'h8888_8888, 4'hF, 1'b1);
      load("ld_w0_kept", 32'h1001_0000, 32'h1111_1111, 1'b0);
      load("ld_w1_kept", 32'h1001_0004, 32'h55AD_BEAA, 1'b0);
      load("ld_wlast_kept", 32'h1001_01FC, 32'hA5A5_5A5A, 1'b0);

      // Held response, with rsp_ready_i raised early during WAIT.
      xact(1'b0, 32'h1001_0004, 32'h0, 4'h0, 5, 1'b1, rd, er);
      check("hold_ld", rd, 32'h55AD_BEAA);
      check("hold_ld_err", 32'(er), 32'd0);

      // Reset during WAIT of a store must abort it.
      store(32'h1001_0008, 32'hCAFE_F00D, 4'hF, 1'b0);
      wait_ready();
      req_valid_i = 1'b1; req_write_i = 1'b1; addr_i = 32'h1001_0008;
      wdata_i = 32'h1234_5678; be_i = 4'hF;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      check("wait_valid", 32'(rsp_valid_o), 32'd0);
      check("wait_ready", 32'(req_ready_o), 32'd0);
      reset = 1'b0;
      #1;
      check("abort_ready", 32'(req_ready_o), 32'd0);
      check("abort_valid", 32'(rsp_valid_o), 32'd0);
      check("abort_rdata", rdata_o, 32'd0);
      check("abort_err", 32'(rsp_error_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_hold_valid", 32'(rsp_valid_o), 32'd0);
      reset = 1'b1;
      #1;
      check("abort_rel_ready", 32'(req_ready_o), 32'd1);
      load("ld_after_abort", 32'h1001_0008, 32'hCAFE_F00D, 1'b0);
      load("ld_w0_after_rst", 32'h1001_0000, 32'h1111_1111, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
